// File: rtl/prom_reader_pkg.sv
// prom_reader_pkg: shared FSM encoding, default PROM profile widths and width-field helper.
package prom_reader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        SAMPLE  = 2'd2,
        PRESENT = 2'd3
    } state_t;

    localparam logic [3:0] IP3601_ADDR_W = 4'd8;
    localparam logic [3:0] IP3601_DATA_W = 4'd4;
    localparam logic [3:0] IP3604_ADDR_W = 4'd9;
    localparam logic [3:0] IP3604_DATA_W = 4'd8;

    function automatic logic [3:0] width_field(input logic [63:0] widths, input int idx);
        return widths[idx*4 +: 4];
    endfunction

endpackage

// File: rtl/prom_access_timer.sv
// prom_access_timer: loadable down-counter that times the PROM access window.
module prom_access_timer #(
    parameter int ACCESS_CYCLES = 50,
    localparam int W = $clog2(ACCESS_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    output logic done_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else if (load_i) cnt_q <= W'(ACCESS_CYCLES - 1);
        else if (cnt_q != '0) cnt_q <= cnt_q - W'(1);
    end

    assign done_o = cnt_q == '0;
endmodule

// File: rtl/prom_scan_reader.sv
// prom_scan_reader: multi-profile PROM reader with manual stepping and valid/ready auto-scan.
// Define PROM_SCAN_CHECKSUM_EN to add the 16-bit sweep checksum output scan_checksum.
module prom_scan_reader
    import prom_reader_pkg::*;
#(
    parameter int NUM_CHIPS = 2,
    parameter int MAX_ADDR_WIDTH = 9,
    parameter int MAX_DATA_WIDTH = 8,
    parameter logic [4*NUM_CHIPS-1:0] CHIP_ADDR_WIDTHS = {IP3604_ADDR_W, IP3601_ADDR_W},
    parameter logic [4*NUM_CHIPS-1:0] CHIP_DATA_WIDTHS = {IP3604_DATA_W, IP3601_DATA_W},
    parameter int ACCESS_CYCLES = 50,
    localparam int CW = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CW-1:0]             chip_index,
    input  logic                      scan_mode,
    input  logic                      increment_pulse,
    input  logic                      decrement_pulse,
    input  logic                      scan_start,
    input  logic [MAX_DATA_WIDTH-1:0] chip_data_port,
    output logic [MAX_ADDR_WIDTH-1:0] chip_address_port,
    output logic [NUM_CHIPS-1:0]      chip_enable_n,
    output logic [MAX_DATA_WIDTH-1:0] data_out,
    output logic [MAX_ADDR_WIDTH-1:0] address_out,
    output logic                      data_valid,
    input  logic                      data_ready,
`ifdef PROM_SCAN_CHECKSUM_EN
    output logic [15:0]               scan_checksum,
`endif
    output logic                      busy,
    output logic                      scan_done
);
    state_t                    state_q, state_d;
    logic [MAX_ADDR_WIDTH-1:0] addr_q, addr_d, last_addr;
    logic [MAX_DATA_WIDTH-1:0] data_mask;
    logic [CW-1:0]             chip_q;
    logic [3:0]                aw, dw;
    logic                      mode_q, mode_d, init_q, load, accept, timer_done;

    assign aw = width_field(64'(CHIP_ADDR_WIDTHS), int'(chip_q));
    assign dw = width_field(64'(CHIP_DATA_WIDTHS), int'(chip_q));
    assign last_addr = MAX_ADDR_WIDTH'((32'd1 << aw) - 32'd1);
    assign data_mask = MAX_DATA_WIDTH'((32'd1 << dw) - 32'd1);
    assign chip_address_port = addr_q;

    prom_access_timer #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (load),
        .done_o (timer_done)
    );

    // A chip_index change pre-empts everything, including a pending handshake.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mode_d  = mode_q;
        load    = 1'b0;
        accept  = 1'b0;
        if (chip_index != chip_q) begin
            state_d = SETTLE;
            addr_d  = '0;
            load    = 1'b1;
            mode_d  = (state_q == IDLE) ? scan_mode : mode_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (init_q || (scan_mode && scan_start)) begin
                        state_d = SETTLE;
                        addr_d  = '0;
                        load    = 1'b1;
                        mode_d  = scan_mode;
                    end else if (!scan_mode && (increment_pulse ^ decrement_pulse)) begin
                        state_d = SETTLE;
                        addr_d  = increment_pulse ? ((addr_q == last_addr) ? '0 : addr_q + MAX_ADDR_WIDTH'(1))
                                                  : ((addr_q == '0) ? last_addr : addr_q - MAX_ADDR_WIDTH'(1));
                        load    = 1'b1;
                        mode_d  = 1'b0;
                    end
                end
                SETTLE:  state_d = timer_done ? SAMPLE : SETTLE;
                SAMPLE:  state_d = mode_q ? PRESENT : IDLE;
                PRESENT: begin
                    if (data_ready) begin
                        accept  = 1'b1;
                        state_d = (addr_q == last_addr) ? IDLE : SETTLE;
                        addr_d  = (addr_q == last_addr) ? addr_q : addr_q + MAX_ADDR_WIDTH'(1);
                        load    = addr_q != last_addr;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            chip_q        <= '0;
            mode_q        <= 1'b0;
            init_q        <= 1'b1;
            chip_enable_n <= '1;
            data_out      <= '0;
            address_out   <= '0;
            data_valid    <= 1'b0;
            busy          <= 1'b0;
            scan_done     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            chip_q        <= chip_index;
            mode_q        <= mode_d;
            init_q        <= 1'b0;
            chip_enable_n <= (state_d == IDLE) ? '1 : ~(NUM_CHIPS'(1) << chip_index);
            busy          <= state_d != IDLE;
            scan_done     <= accept && addr_q == last_addr;
            if (load || accept) data_valid <= 1'b0;
            else if (state_q == SAMPLE) begin
                data_out    <= chip_data_port & data_mask;
                address_out <= addr_q;
                data_valid  <= 1'b1;
            end
        end
    end

`ifdef PROM_SCAN_CHECKSUM_EN
    logic [15:0] sum_q;
    logic        scan_go;

    assign scan_go = state_q == IDLE && chip_index == chip_q && !init_q && scan_mode && scan_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q         <= '0;
            scan_checksum <= '0;
        end else if (scan_go) sum_q <= '0;
        else if (accept) begin
            sum_q <= sum_q + 16'(data_out);
            if (addr_q == last_addr) scan_checksum <= sum_q + 16'(data_out);
        end
    end
`endif
endmodule

// File: tb/tb_prom_scan_reader.sv
// tb_prom_scan_reader: randomized self-checking bench against a PROM-image reference model.
module tb_prom_scan_reader;
    localparam int AC = 4;

    logic       clk = 0, reset = 1, chip_index = 0, scan_mode = 0;
    logic       increment_pulse = 0, decrement_pulse = 0, scan_start = 0, data_ready = 0;
    logic [7:0] chip_data_port, data_out;
    logic [8:0] chip_address_port, address_out;
    logic [1:0] chip_enable_n;
    logic       data_valid, busy, scan_done;
`ifdef PROM_SCAN_CHECKSUM_EN
    logic [15:0] scan_checksum;
`endif
    logic [7:0] mem [512];
    int tests = 0, fails = 0;

    always #5 clk = ~clk;
    assign chip_data_port = mem[chip_address_port];

    prom_scan_reader #(.ACCESS_CYCLES(AC)) dut (
        .clk               (clk),
        .reset             (reset),
        .chip_index        (chip_index),
        .scan_mode         (scan_mode),
        .increment_pulse   (increment_pulse),
        .decrement_pulse   (decrement_pulse),
        .scan_start        (scan_start),
        .chip_data_port    (chip_data_port),
        .chip_address_port (chip_address_port),
        .chip_enable_n     (chip_enable_n),
        .data_out          (data_out),
        .address_out       (address_out),
        .data_valid        (data_valid),
        .data_ready        (data_ready),
`ifdef PROM_SCAN_CHECKSUM_EN
        .scan_checksum     (scan_checksum),
`endif
        .busy              (busy),
        .scan_done         (scan_done)
    );

    function automatic int last_of(input logic c);
        return c ? 511 : 255;
    endfunction

    function automatic logic [7:0] mask_of(input logic c);
        return c ? 8'hFF : 8'h0F;
    endfunction

    task automatic fill(input int kind);
        for (int i = 0; i < 512; i++)
            mem[i] = (kind == 0) ? 8'hA5 : (kind == 1) ? 8'(i) : (kind == 2) ? 8'hFF : 8'($urandom);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!data_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s: busy=%b, required 0", tag, busy);
        end
    endtask

    task automatic pulse(input logic inc, input logic dec);
        increment_pulse = inc;
        decrement_pulse = dec;
        @(negedge clk);
        increment_pulse = 0;
        decrement_pulse = 0;
    endtask

    task automatic test_reset;
        int n;
        fill(0);
        reset = 1;
        repeat (3) @(negedge clk);
        tests++;
        if ({chip_enable_n, data_valid, busy, scan_done, chip_address_port, data_out, address_out} !== {2'b11, 3'b000, 9'd0, 8'd0, 9'd0}) begin
            fails++;
            $display("FAIL reset_values: en_n=%b valid=%b busy=%b done=%b addr=%0d data=%h aout=%0d, required 11/0/0/0/0/00/0",
                     chip_enable_n, data_valid, busy, scan_done, chip_address_port, data_out, address_out);
        end
        reset = 0;
        @(negedge clk);
        n = 1;
        tests++;
        if ({chip_address_port, chip_enable_n, busy, data_valid} !== {9'd0, 2'b10, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL initial_read_start: addr=%0d en_n=%b busy=%b valid=%b, required 0/10/1/0",
                     chip_address_port, chip_enable_n, busy, data_valid);
        end
        while (!data_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        // n counts from the edge that loaded the address, so valid lands AC+1 edges later
        tests++;
        if (n !== AC + 2) begin
            fails++;
            $display("FAIL initial_latency: valid at edge %0d, required %0d", n, AC + 2);
        end
        tests++;
        if ({data_valid, data_out, address_out} !== {1'b1, 8'h05, 9'd0}) begin
            fails++;
            $display("FAIL initial_data: valid=%b data=%h addr=%0d, required 1/05/0", data_valid, data_out, address_out);
        end
    endtask

    task automatic test_manual;
        int n, a;
        logic c;
        logic [1:0] r;
        fill(3);
        chip_index = 1;
        @(negedge clk);
        tests++;
        if ({data_valid, chip_address_port, chip_enable_n} !== {1'b0, 9'd0, 2'b01}) begin
            fails++;
            $display("FAIL chip1_select: valid=%b addr=%0d en_n=%b, required 0/0/01", data_valid, chip_address_port, chip_enable_n);
        end
        wait_valid(n);
        pulse(0, 1);
        tests++;
        if ({chip_address_port, data_valid} !== {9'd511, 1'b0}) begin
            fails++;
            $display("FAIL dec_wrap: addr=%0d valid=%b, required 511/0", chip_address_port, data_valid);
        end
        wait_valid(n);
        tests++;
        if ({data_valid, address_out, data_out} !== {1'b1, 9'd511, mem[511]}) begin
            fails++;
            $display("FAIL dec_wrap_data: valid=%b addr=%0d data=%h, required 1/511/%h", data_valid, address_out, data_out, mem[511]);
        end
        pulse(1, 0);
        wait_valid(n);
        tests++;
        if ({data_valid, address_out, data_out} !== {1'b1, 9'd0, mem[0]}) begin
            fails++;
            $display("FAIL inc_wrap: valid=%b addr=%0d data=%h, required 1/0/%h", data_valid, address_out, data_out, mem[0]);
        end
        pulse(1, 1);
        tests++;
        if ({chip_address_port, busy, data_valid} !== {9'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL both_pulses: addr=%0d busy=%b valid=%b, required 0/0/1", chip_address_port, busy, data_valid);
        end
        pulse(1, 0);
        pulse(1, 0);
        wait_valid(n);
        tests++;
        if ({data_valid, address_out} !== {1'b1, 9'd1}) begin
            fails++;
            $display("FAIL busy_pulse_drop: valid=%b addr=%0d, required 1/1", data_valid, address_out);
        end
        a = 1;
        c = 1;
        for (int i = 0; i < 24; i++) begin
            if (i == 12) begin
                chip_index = 0;
                c = 0;
                a = 0;
                @(negedge clk);
                wait_valid(n);
            end
            r = 2'($urandom_range(0, 3));
            pulse(r[0], r[1]);
            if (r == 2'b01) a = (a == last_of(c)) ? 0 : a + 1;
            else if (r == 2'b10) a = (a == 0) ? last_of(c) : a - 1;
            wait_valid(n);
            tests++;
            if ({data_valid, address_out, data_out} !== {1'b1, 9'(a), mem[a] & mask_of(c)}) begin
                fails++;
                $display("FAIL manual_step %0d: valid=%b addr=%0d data=%h, required 1/%0d/%h",
                         i, data_valid, address_out, data_out, a, mem[a] & mask_of(c));
            end
        end
        wait_idle("manual_idle");
    endtask

    task automatic run_scan(input logic c, input int stall_addr, input bit rand_ready);
        int exp_a, stall, cyc;
        logic [15:0] sum;
        logic [7:0] exp_d;
        bit exp_done, pend, finished;
        scan_mode = 0;
        if (chip_index !== c) begin
            chip_index = c;
            @(negedge clk);
        end
        wait_idle("scan_pre_idle");
        scan_mode = 1;
        data_ready = 0;
        scan_start = 1;
        @(negedge clk);
        scan_start = 0;
        exp_a = 0;
        stall = 0;
        sum = 0;
        pend = 0;
        finished = 0;
        cyc = 0;
        while (!finished && cyc < 20000) begin
            exp_done = pend;
            pend = 0;
            tests++;
            if (scan_done !== exp_done) begin
                fails++;
                $display("FAIL scan_done at beat %0d: got %b, required %b", exp_a, scan_done, exp_done);
            end
            if (exp_done) begin
                tests++;
                if (busy !== 1'b0) begin
                    fails++;
                    $display("FAIL busy_after_done: got %b, required 0", busy);
                end
`ifdef PROM_SCAN_CHECKSUM_EN
                tests++;
                if (scan_checksum !== sum) begin
                    fails++;
                    $display("FAIL checksum_model: got %h, required %h", scan_checksum, sum);
                end
`endif
                finished = 1;
            end else if (data_valid) begin
                exp_d = mem[exp_a] & mask_of(c);
                tests++;
                if ({address_out, chip_address_port, data_out} !== {9'(exp_a), 9'(exp_a), exp_d}) begin
                    fails++;
                    $display("FAIL scan_beat: aout=%0d addr=%0d data=%h, required %0d/%0d/%h",
                             address_out, chip_address_port, data_out, exp_a, exp_a, exp_d);
                end
                if (exp_a == stall_addr && stall < 10) begin
                    data_ready = 0;
                    stall++;
                end else data_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (data_ready) begin
                    sum += 16'(exp_d);
                    pend = exp_a == last_of(c);
                    exp_a++;
                end
            end else data_ready = 1'($urandom_range(0, 1));
            if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end
        tests++;
        if (!finished || exp_a != last_of(c) + 1) begin
            fails++;
            $display("FAIL scan_length: finished=%b beats=%0d, required 1/%0d", finished, exp_a, last_of(c) + 1);
        end
        data_ready = 0;
        scan_mode = 0;
        repeat (3) @(negedge clk);
        tests++;
        if ({scan_done, busy} !== 2'b00) begin
            fails++;
            $display("FAIL scan_post: done=%b busy=%b, required 0/0", scan_done, busy);
        end
    endtask

    task automatic test_scan;
        fill(1);
        run_scan(0, -1, 0);
    endtask

    task automatic test_stall;
        fill(3);
        run_scan(0, 7, 0);
    endtask

    task automatic test_random_scan;
        fill(3);
        run_scan(1, -1, 1);
    endtask

    task automatic test_chip_change;
        int n = 0;
        bit seen = 0;
        fill(3);
        scan_mode = 0;
        chip_index = 0;
        @(negedge clk);
        wait_idle("chg_pre_idle");
        scan_mode = 1;
        data_ready = 1;
        scan_start = 1;
        @(negedge clk);
        scan_start = 0;
        while (!(data_valid && address_out == 9'd100) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if ({data_valid, address_out} !== {1'b1, 9'd100}) begin
            fails++;
            $display("FAIL chg_reach100: valid=%b addr=%0d, required 1/100", data_valid, address_out);
        end
        chip_index = 1;
        @(negedge clk);
        tests++;
        if ({data_valid, chip_address_port, chip_enable_n, scan_done, busy} !== {1'b0, 9'd0, 2'b01, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL chip_abort: valid=%b addr=%0d en_n=%b done=%b busy=%b, required 0/0/01/0/1",
                     data_valid, chip_address_port, chip_enable_n, scan_done, busy);
        end
        repeat (30) begin
            @(negedge clk);
            if (scan_done) seen = 1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL chg_no_done: scan_done seen=%b, required 0", seen);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        reset = 1;
        scan_mode = 0;
        data_ready = 0;
        @(negedge clk);
        tests++;
        if ({chip_enable_n, data_valid, busy, scan_done, chip_address_port, data_out, address_out} !== {2'b11, 3'b000, 9'd0, 8'd0, 9'd0}) begin
            fails++;
            $display("FAIL mid_reset: en_n=%b valid=%b busy=%b done=%b addr=%0d data=%h aout=%0d, required 11/0/0/0/0/00/0",
                     chip_enable_n, data_valid, busy, scan_done, chip_address_port, data_out, address_out);
        end
        chip_index = 0;
        reset = 0;
        @(negedge clk);
        wait_valid(n);
        tests++;
        if ({data_valid, address_out, data_out} !== {1'b1, 9'd0, mem[0] & 8'h0F}) begin
            fails++;
            $display("FAIL mid_reset_reread: valid=%b addr=%0d data=%h, required 1/0/%h", data_valid, address_out, data_out, mem[0] & 8'h0F);
        end
        wait_idle("mid_reset_idle");
    endtask

`ifdef PROM_SCAN_CHECKSUM_EN
    task automatic test_checksum;
        fill(2);
        run_scan(1, -1, 0);
        tests++;
        if (scan_checksum !== 16'hFE00) begin
            fails++;
            $display("FAIL checksum_ff: got %h, required FE00", scan_checksum);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_manual;
        test_scan;
        test_stall;
        test_random_scan;
        test_chip_change;
        test_reset_mid;
`ifdef PROM_SCAN_CHECKSUM_EN
        test_checksum;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/prom_scan_reader.md
Name: prom_scan_reader

Overview:
Parametrised successor to the single-chip rom_reader, built for the bipolar PROM reader board.
- Serves NUM_CHIPS chip profiles from one address/data bus. Each profile has its own address width, data width and active-low enable line.
- Manual mode: single-address stepping from debounced button pulses.
- Auto-scan mode: sweeps the whole chip and streams (address, data) over a valid/ready handshake to a UART/dump sink.
- Sits between the board debouncers/mode switches and the address display/dump path.

Parameters:
NUM_CHIPS, 2, number of chip profiles (chip 0 = IP3601, chip 1 = IP3604)
MAX_ADDR_WIDTH, 9, width of the shared address bus
MAX_DATA_WIDTH, 8, width of the shared data bus
CHIP_ADDR_WIDTHS, {4'd9,4'd8}, packed 4-bit address width per chip, chip 0 in LSBs
CHIP_DATA_WIDTHS, {4'd8,4'd4}, packed 4-bit data width per chip, chip 0 in LSBs
ACCESS_CYCLES, 50, clk cycles from address/enable change to sampling data (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
chip_index  in  $clog2(NUM_CHIPS)  selected chip profile
scan_mode  in  1  0 = manual stepping, 1 = auto-scan
increment_pulse  in  1  one-cycle debounced increment request
decrement_pulse  in  1  one-cycle debounced decrement request
scan_start  in  1  one-cycle pulse that starts a sweep (scan_mode=1 only)
chip_data_port  in  MAX_DATA_WIDTH  data from the PROM
chip_address_port  out  MAX_ADDR_WIDTH  address to the PROM
chip_enable_n  out  NUM_CHIPS  active-low enable, one-hot-low for the selected chip
data_out  out  MAX_DATA_WIDTH  sampled data, zero-extended above the chip data width
address_out  out  MAX_ADDR_WIDTH  address belonging to data_out
data_valid  out  1  data_out/address_out valid
data_ready  in  1  sink accepts the beat
busy  out  1  high in any state except IDLE
scan_done  out  1  one-cycle pulse after the last beat of a sweep is accepted

Behaviour:
Reset values:
- All outputs 0, except chip_enable_n = all 1s.
- FSM in IDLE.
- After reset, the first cycle with reset low loads address 0 and enters SETTLE (initial read).

Addressing:
- Last address for the selected chip = 2^CHIP_ADDR_WIDTHS[chip]-1.
- Address bits above the chip's address width are driven 0.
- Data bits above the chip's data width are masked to 0 at sampling.

FSM states: IDLE, SETTLE, SAMPLE, PRESENT.
- SETTLE: counter loads ACCESS_CYCLES-1 and counts to 0. chip_enable_n is asserted for the selected chip from SETTLE entry until the PRESENT handshake completes.
- SAMPLE: one cycle; registers chip_data_port into data_out and the current address into address_out.
  - Manual mode: go to IDLE with data_valid=1. data_valid stays high until the next address change; it is level-only status and ignores data_ready.
  - Scan mode: go to PRESENT.
- PRESENT: data_valid=1, outputs held stable until data_ready.
  - On accept, if address == last: pulse scan_done, go to IDLE.
  - Otherwise: address+1, go to SETTLE.
- Latency from address change to data_valid = ACCESS_CYCLES+1 clk.

Manual stepping (IDLE, scan_mode=0):
- increment_pulse: address+1, wrapping last->0.
- decrement_pulse: address-1, wrapping 0->last.
- Both pulses in the same cycle: ignored.
- Pulses outside IDLE: dropped.

Scan (scan_mode=1):
- scan_start in IDLE: address=0, go to SETTLE.
- scan_start while busy: ignored.

chip_index change (any state, sampled every cycle vs registered copy):
- Abort the current operation, drop data_valid, set address=0, enter SETTLE.
- No scan_done.

scan_mode change mid-sweep: ignored until IDLE.

reset mid-operation: immediate return to the reset values; no partial beat is ever presented.

Optional Feature:
PROM_SCAN_CHECKSUM_EN
- Defined: adds output scan_checksum [15:0] plus internal accumulator.
  - Accumulator cleared on scan_start.
  - Adds zero-extended data on each accepted PRESENT beat, modulo 2^16.
  - scan_checksum updates to the final sum in the same cycle scan_done pulses; otherwise holds.
  - Cleared by reset.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
Shared package prom_reader_pkg:
- FSM state encoding (2-bit localparams).
- Default IP3601/IP3604 address/data widths.
- Function extracting a 4-bit field from a packed width vector.

Sub-module prom_access_timer: loadable down-counter with load/done, width $clog2(ACCESS_CYCLES+1).

Test Plan:
- Reset release, chip_index=0, ACCESS_CYCLES=4, chip drives 0xA5 -> address 0, chip_enable_n=2'b10, data_valid at cycle 5 after release, data_out=0x05 (masked to 4 bits).
- Manual, chip 1, address 0, decrement_pulse -> address 511; then increment_pulse -> address 0; both pulses together -> address unchanged.
- Scan chip 0, data=address[3:0], data_ready=1 -> 256 beats with addresses 0..255 in order, scan_done exactly once after beat 255, busy low the next cycle.
- Scan with data_ready held low 10 cycles at address 7 -> data_out/address_out stable, no address advance, resumes at 8 after accept.
- chip_index 0->1 at address 100 mid-scan -> data_valid drops, address 0, chip_enable_n=2'b01, no scan_done.
- PROM_SCAN_CHECKSUM_EN, chip 1, data=0xFF everywhere -> scan_checksum = 512*255 mod 65536 = 0xFE00 at scan_done.
